// File: rtl/mux_channel_if.sv
// Handshake bundle between the requesters, the mux datapath
// and the channel scheduler.
interface mux_channel_if;
  logic [3:0] req;
  logic       t_in;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       data_out;
  logic       data_valid;
  logic [1:0] valid_id;
  logic       busy;

  modport master (
    output req,
    output t_in,
    input  sel,
    input  gnt,
    input  data_out,
    input  data_valid,
    input  valid_id,
    input  busy
  );

  modport slave (
    input  req,
    input  t_in,
    output sel,
    output gnt,
    output data_out,
    output data_valid,
    output valid_id,
    output busy
  );
endinterface

// File: rtl/mux_channel_scheduler.sv
// Round-robin owner of the 4:1 mux selects: grant, hold the
// select for the settle time, sample T and return it.
module mux_channel_scheduler #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic          clk,
  input  logic          reset,
  mux_channel_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic [1:0]       valid_id_q, valid_id_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       found;
  logic [1:0] pick;
  logic [1:0] idx;

  // first set request at or after ptr, wrapping modulo 4
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    gnt_d        = gnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    valid_id_d   = valid_id_q;
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = 4'(1) << pick;
          sel_d   = pick;
          ptr_d   = pick + 2'd1;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (!bus.req[sel_q]) begin
          gnt_d   = 4'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SAMPLE: begin
        if (!bus.req[sel_q]) begin
          gnt_d   = 4'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          data_out_d   = bus.t_in;
          valid_id_d   = sel_q;
          data_valid_d = 1'b1;
          gnt_d        = 4'd0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        gnt_d   = 4'd0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      sel_q        <= 2'd0;
      gnt_q        <= 4'd0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      valid_id_q   <= 2'd0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      valid_id_q   <= valid_id_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.gnt        = gnt_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.valid_id   = valid_id_q;
  assign bus.busy       = busy_q;

endmodule
